// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths and channel encoding for the oversampling I2S receiver.
package i2s_pkg;

    localparam int DATA_W_DEF      = 24;
    localparam int CNT_W_DEF       = 6;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

endpackage

// File: rtl/i2s_oversample_rx_if.sv
// i2s_oversample_rx_if: stereo frame valid/ready bus toward the DSP path.
interface i2s_oversample_rx_if import i2s_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ldata;
    logic [DATA_W-1:0] rdata;

    modport master (output out_valid, ldata, rdata, input out_ready);
    modport slave  (input out_valid, ldata, rdata, output out_ready);

endinterface

// File: rtl/i2s_oversample_rx_pin_sync.sv
// pin_sync: multi-flop synchronizer with a registered rising-edge strobe.
module pin_sync import i2s_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise_q;

    // q_o is taken one flop later than the last sync stage so it lines up with rise_o
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    assign q_o    = dly_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/i2s_oversample_rx.sv
// i2s_oversample_rx: I2S slave receiver oversampling bck/lrck/adata in clk,
// assembling left/right words into stereo frames on a valid/ready bus.
module i2s_oversample_rx import i2s_pkg::*; #(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bck,
    input  logic                       lrck,
    input  logic                       adata,
    i2s_oversample_rx_if.master        out_if,
    output logic                       synced,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    logic              bck_s, bck_rise, ws, sd;
    logic              lrck_rise_unused, adata_rise_unused;
    logic [DATA_W-1:0] shreg_q, shreg_d, shreg_bit;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ch_e               ws_prev_q, ws_prev_d;
    logic [DATA_W-1:0] lhold_q, lhold_d;
    logic              left_ok_q, left_ok_d;
    logic              synced_q, synced_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ws_chg, left_done, right_done, frame, load, drop;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bck (
        .clk(clk), .rst(rst), .d_i(bck), .q_o(bck_s), .rise_o(bck_rise)
    );
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
        .clk(clk), .rst(rst), .d_i(lrck), .q_o(ws), .rise_o(lrck_rise_unused)
    );
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_adata (
        .clk(clk), .rst(rst), .d_i(adata), .q_o(sd), .rise_o(adata_rise_unused)
    );

    // Slot bits past DATA_W never match a position and are dropped
    always_comb begin
        shreg_bit = shreg_q;
        for (int i = 0; i < DATA_W; i++)
            if (cnt_q == CNT_W'(DATA_W - 1 - i)) shreg_bit[i] = sd;
    end

    // Every strobe is a bit of slot ws_prev; a ws change marks that slot's LSB
    always_comb begin
        ws_chg      = bck_rise && (ch_e'(ws) != ws_prev_q);
        left_done   = ws_chg && (ws_prev_q == CH_LEFT);
        right_done  = ws_chg && (ws_prev_q == CH_RIGHT);
        frame       = right_done && left_ok_q;
        load        = frame && (!out_valid_q || out_if.out_ready);
        drop        = frame && !load;
        shreg_d     = !bck_rise ? shreg_q : ws_chg ? '0 : shreg_bit;
        cnt_d       = !bck_rise ? cnt_q : ws_chg ? '0 : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
        ws_prev_d   = bck_rise ? ch_e'(ws) : ws_prev_q;
        lhold_d     = left_done ? shreg_bit : lhold_q;
        left_ok_d   = left_done ? synced_q : right_done ? 1'b0 : left_ok_q;
        synced_d    = synced_q | right_done;
        overflow_d  = drop | (overflow_q & ~ovf_clr);
        out_valid_d = load | (out_valid_q & ~out_if.out_ready);
        ldata_d     = load ? lhold_q : ldata_q;
        rdata_d     = load ? shreg_bit : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            ws_prev_q   <= CH_LEFT;
            lhold_q     <= '0;
            left_ok_q   <= 1'b0;
            synced_q    <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ldata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ws_prev_q   <= ws_prev_d;
            lhold_q     <= lhold_d;
            left_ok_q   <= left_ok_d;
            synced_q    <= synced_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            ldata_q     <= ldata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.ldata     = ldata_q;
    assign out_if.rdata     = rdata_q;
    assign synced           = synced_q;
    assign overflow         = overflow_q;

    // bck level itself is only consumed through the edge strobe
    logic bck_level_unused;
    assign bck_level_unused = bck_s;

endmodule

// File: doc/i2s_oversample_rx.md
Name: i2s_oversample_rx

Overview:
- Single-clock I2S receiver for the ADC master-mode audio bus. Samples the asynchronous bck/lrck/adata pins with the system clock.
- Assembles left/right PCM words and presents one stereo frame at a time on a valid/ready handshake to the ADC interface / DSP path.
- Replaces bck-domain capture with a design fully inside clk. No second clock domain.

Parameters:
- DATA_W, 24, bits per output sample; MSB-first, left-justified within the slot.
- CNT_W, 6, bit-counter width; slots up to 2^CNT_W-1 bits.
- SYNC_STAGES, 2, synchronizer flops per input pin (≥2).

Ports:
- clk  in  1  system clock. Must satisfy bck high and low phases each ≥ 2 clk periods.
- rst  in  1  reset; synchronous, active-high.
- bck  in  1  I2S bit clock from the ADC; asynchronous.
- lrck  in  1  I2S word select; 0 = left, 1 = right; asynchronous.
- adata  in  1  I2S serial data; asynchronous.
- out_valid  out  1  a stereo frame is held on ldata/rdata.
- out_ready  in  1  consumer accepts the frame when out_valid & out_ready.
- ldata  out  DATA_W  left sample.
- rdata  out  DATA_W  right sample.
- synced  out  1  a complete left slot has been framed since reset.
- overflow  out  1  sticky: a completed frame was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset values: out_valid=0, ldata=0, rdata=0, synced=0, overflow=0; shift register, counter and internal flags cleared. Reset applied mid-slot abandons any partial word.
- Input path: each pin passes through SYNC_STAGES flops. A one-cycle strobe bck_rise fires when the synced bck goes 0→1. All capture happens only on bck_rise cycles.
- On bck_rise, sample ws = synced lrck and sd = synced adata. Compare ws against ws_prev, the ws from the previous bck_rise.
- Slot definition: the bits of the slot for channel C are sampled on bck_rise strobes.
  - The slot starts on the strobe after ws first reads C.
  - The slot ends on, and includes, the strobe where ws first reads !C. This is the I2S one-bit delay: the LSB coincides with the ws change.
- Bit placement: on each slot bit, if cnt < DATA_W, write sd to shreg[DATA_W-1-cnt]. Then increment cnt, saturating at 2^CNT_W-1.
  - Bits beyond DATA_W are discarded.
  - Short slots leave the low bits zero-padded.
- Word completion: on a strobe where ws != ws_prev, place the bit first, then latch shreg into the channel holding register selected by ws_prev. Clear shreg and cnt in the same cycle.
- Left completes (ws 0→1):
  - Store lhold.
  - Set left_ok if synced.
- synced: sets on the first ws 1→0 change after reset. From then on the next left slot is complete.
  - Words completed before synced=1 are discarded.
  - The first ws 0→1 after reset does not set left_ok.
- Right completes (ws 1→0) with left_ok=1 forms a frame. Clear left_ok.
  - If out_valid=0, or out_valid & out_ready in the same cycle: load ldata=lhold and rdata=shreg-with-LSB, and assert out_valid on the next clk.
  - Otherwise drop the frame, set overflow=1, and leave ldata/rdata unchanged.
- Handshake:
  - out_valid stays high and the data is stable until out_valid & out_ready.
  - On acceptance without a new frame, out_valid drops on the next cycle.
- Latency: out_valid rises 1 clk after the bck_rise strobe carrying the right-slot LSB. That is SYNC_STAGES+2 clk after the pin edge.
- overflow: ovf_clr clears it. If a set and ovf_clr occur in the same cycle, set wins.
- Glitch-free output: ldata and rdata change only on frame load.

Decomposition:
- Shared package i2s_pkg:
  - DATA_W_DEF = 24.
  - CNT_W_DEF = 6.
  - Channel enum CH_LEFT = 0, CH_RIGHT = 1.
- Sub-module pin_sync: parameterised SYNC_STAGES synchronizer with registered rise-edge strobe output. Instantiated three times; the edge output is used only for bck.
- The top level holds the capture shift register, counter, holding registers and handshake.

Test Plan:
- Setup for all scenarios: clk = 8× bck, 32-bit slots, starting at a ws 1→0 change. Send L=0x123456, R=0xABCDEF (8 trailing zero bits each) → ldata=0x123456, rdata=0xABCDEF, one out_valid, synced=1, out_valid SYNC_STAGES+2 clk after the final right-LSB bck rise.
- 16-bit slots, L=0xBEEF, R=0x0001 → ldata=0xBEEF00, rdata=0x000100.
- Stream starts mid right slot after reset → no out_valid until the first full L+R pair. Partial words are discarded.
- out_ready=0 across three frames (0x111111/0x222222, then 0x333333/…) → ldata stays 0x111111, overflow=1. ovf_clr pulse → overflow=0. Then ready=1 → frame accepted, out_valid drops.
- out_ready asserted in the exact cycle a new frame completes while out_valid=1 → new frame loaded, out_valid stays 1, overflow stays 0.
- rst pulsed mid left slot → all outputs 0 next cycle, synced=0. The first frame after re-sync is correct.
